// File: rtl/sa4_skew_feeder_pkg.sv
// -----------------------------------------------------------------------------
// sa_pkg -- shared definitions for the 4x4 systolic-array skew feeder.
//   state_t      : feeder FSM encoding (IDLE/STREAM/FLUSH/DONE)
//   N            : array edge (lane count)
//   LANE_W       : default operand lane slice width in bits
//   FLUSH_LEN    : cycles spent draining the skew chain after the last beat
//   FLUSH_LOAD   : down-counter preload that yields FLUSH_LEN cycles
//   is_accepting : states in which the feeder can take a beat
// -----------------------------------------------------------------------------
package sa_pkg;

   localparam int N         = 4;
   localparam int LANE_W    = 8;
   localparam int FLUSH_LEN = 2 * (N - 1) + 1;

   // The counter runs FLUSH_LOAD..0 inclusive, i.e. FLUSH_LEN cycles.
   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_LEN - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      FLUSH  = 2'd2,
      DONE   = 2'd3
   } state_t;

   function automatic logic is_accepting(input state_t s);
      return (s == IDLE) || (s == STREAM);
   endfunction

endpackage : sa_pkg

// File: rtl/sa4_skew_feeder_if.sv
// -----------------------------------------------------------------------------
// sa4_skew_feeder_if -- input beat stream into the skew feeder.
//   in_valid  : source has a beat this cycle
//   in_ready  : feeder accepts a beat this cycle
//   in_act    : activation column, lane 0 in the top WIDTH bits
//   in_weight : weight row, same lane packing as in_act
//   in_last   : final beat of a tile
// Modports: master = beat source, slave = feeder.
// -----------------------------------------------------------------------------
interface sa4_skew_feeder_if #(
   parameter int WIDTH = 8
) ();

   logic                 in_valid;
   logic                 in_ready;
   logic [4*WIDTH-1:0]   in_act;
   logic [4*WIDTH-1:0]   in_weight;
   logic                 in_last;

   modport master (
      output in_valid,
      output in_act,
      output in_weight,
      output in_last,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_act,
      input  in_weight,
      input  in_last,
      output in_ready
   );

endinterface : sa4_skew_feeder_if

// File: rtl/sa4_skew_feeder_skew_lane.sv
// -----------------------------------------------------------------------------
// sa_skew_lane -- DEPTH-deep, WIDTH-bit shift register with async reset.
// Used as one diagonal lane of the skew chain: d_out is d_in delayed DEPTH
// cycles.
//   clk   : clock, rising edge
//   rstn  : asynchronous active-low reset, clears every stage
//   d_in  : lane input
//   d_out : lane output (last stage, registered)
// -----------------------------------------------------------------------------
module sa_skew_lane #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [WIDTH-1:0] d_in,
   output logic [WIDTH-1:0] d_out
);

   logic [WIDTH-1:0] sr_q [DEPTH];
   logic [WIDTH-1:0] sr_d [DEPTH];

   // Next value of each stage: stage 0 takes the input, others shift.
   always_comb begin
      sr_d[0] = d_in;
      for (int i = 1; i < DEPTH; i++) begin
         sr_d[i] = sr_q[i-1];
      end
   end

   // Stage registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < DEPTH; i++) begin
            sr_q[i] <= {WIDTH{1'b0}};
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            sr_q[i] <= sr_d[i];
         end
      end
   end

   assign d_out = sr_q[DEPTH-1];

endmodule : sa_skew_lane

// File: rtl/sa4_skew_feeder.sv
// -----------------------------------------------------------------------------
// sa4_skew_feeder -- feeds a 4x4 systolic array with diagonally skewed
// activation and weight operands, and sequences the tile with a small FSM.
//
// Ports:
//   clk        : clock, rising edge
//   rstn       : asynchronous active-low reset (discards any tile in flight)
//   s_if       : input beat stream (sa4_skew_feeder_if.slave)
//   activation : skewed activation edge, lane i = beat lane i delayed i+1
//   weight     : skewed weight edge, same skew as activation
//   control    : array accumulate-enable
//   busy       : FSM is not IDLE
//   done       : one-cycle pulse at the end of a tile
//   beat_cnt   : accepted beats of the current / last tile
//
// Build option: define SA4_FEEDER_CNT_EN to implement beat_cnt; when left
// undefined there is no counter and beat_cnt is tied to zero.
// Only N = 4 is supported.
// -----------------------------------------------------------------------------
module sa4_skew_feeder #(
   parameter int WIDTH = sa_pkg::LANE_W,
   parameter int N     = 4
) (
   input  logic                clk,
   input  logic                rstn,
   sa4_skew_feeder_if.slave    s_if,
   output logic [4*WIDTH-1:0]  activation,
   output logic [4*WIDTH-1:0]  weight,
   output logic                control,
   output logic                busy,
   output logic                done,
   output logic [15:0]         beat_cnt
);

   import sa_pkg::*;

   state_t       state_q,     state_d;
   logic [2:0]   flush_cnt_q, flush_cnt_d;
   logic         control_q,   control_d;
   logic         done_q,      done_d;
   logic         busy_q,      busy_d;
   logic         in_ready_q,  in_ready_d;

   logic                accept_s;
   logic [4*WIDTH-1:0]  act_in_s;
   logic [4*WIDTH-1:0]  wt_in_s;

   assign accept_s = s_if.in_valid & in_ready_q;

   // Anything other than an accepted beat pushes zeros into the chain so
   // bubbles stay aligned and the outputs drain to zero.
   always_comb begin
      if (accept_s) begin
         act_in_s = s_if.in_act;
         wt_in_s  = s_if.in_weight;
      end else begin
         act_in_s = {(4*WIDTH){1'b0}};
         wt_in_s  = {(4*WIDTH){1'b0}};
      end
   end

   // FSM next state and flush down-counter.
   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      case (state_q)
         IDLE, STREAM: begin
            if (accept_s) begin
               if (s_if.in_last) begin
                  state_d     = FLUSH;
                  flush_cnt_d = FLUSH_LOAD;
               end else begin
                  state_d = STREAM;
               end
            end else begin
               state_d = state_q;
            end
         end
         FLUSH: begin
            if (flush_cnt_q == 3'd0) begin
               state_d = DONE;
            end else begin
               flush_cnt_d = flush_cnt_q - 3'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d     = IDLE;
            flush_cnt_d = 3'd0;
         end
      endcase
   end

   // Registered outputs. control lags the state by one cycle so that it
   // rises together with the first lane-0 operand leaving the chain.
   always_comb begin
      control_d  = (state_q == STREAM) || (state_q == FLUSH) ||
                   ((state_q == IDLE) && accept_s);
      done_d     = (state_q == DONE);
      busy_d     = (state_d != IDLE);
      in_ready_d = is_accepting(state_d);
   end

   // FSM and output registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         flush_cnt_q <= 3'd0;
         control_q   <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         in_ready_q  <= 1'b1;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
         control_q   <= control_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         in_ready_q  <= in_ready_d;
      end
   end

   assign s_if.in_ready = in_ready_q;
   assign control       = control_q;
   assign done          = done_q;
   assign busy          = busy_q;

   // Diagonal skew: lane i passes through i+1 registers.
   for (genvar i = 0; i < N; i++) begin : g_lane
      sa_skew_lane #(.WIDTH(WIDTH), .DEPTH(i + 1)) u_act (
         .clk   (clk),
         .rstn  (rstn),
         .d_in  (act_in_s[4*WIDTH-1-i*WIDTH -: WIDTH]),
         .d_out (activation[4*WIDTH-1-i*WIDTH -: WIDTH])
      );
      sa_skew_lane #(.WIDTH(WIDTH), .DEPTH(i + 1)) u_wt (
         .clk   (clk),
         .rstn  (rstn),
         .d_in  (wt_in_s[4*WIDTH-1-i*WIDTH -: WIDTH]),
         .d_out (weight[4*WIDTH-1-i*WIDTH -: WIDTH])
      );
   end

`ifdef SA4_FEEDER_CNT_EN
   logic [15:0] beat_cnt_q, beat_cnt_d;

   // Beat counter: restarts at 1 on the first beat of a tile (accepted in
   // IDLE), saturates, and holds when no beat is accepted.
   always_comb begin
      if (accept_s) begin
         if (state_q == IDLE) begin
            beat_cnt_d = 16'd1;
         end else if (beat_cnt_q == 16'hFFFF) begin
            beat_cnt_d = beat_cnt_q;
         end else begin
            beat_cnt_d = beat_cnt_q + 16'd1;
         end
      end else begin
         beat_cnt_d = beat_cnt_q;
      end
   end

   // Beat counter register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         beat_cnt_q <= 16'd0;
      end else begin
         beat_cnt_q <= beat_cnt_d;
      end
   end

   assign beat_cnt = beat_cnt_q;
`else
   assign beat_cnt = 16'd0;
`endif

endmodule : sa4_skew_feeder

// File: tb/tb_sa4_skew_feeder.sv
// -----------------------------------------------------------------------------
// tb_sa4_skew_feeder -- directed self-checking bench for sa4_skew_feeder.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_sa4_skew_feeder;

   logic        clk;
   logic        rstn;
   logic [31:0] activation;
   logic [31:0] weight;
   logic        control;
   logic        busy;
   logic        done;
   logic [15:0] beat_cnt;

   int tests_run;
   int tests_failed;

`ifdef SA4_FEEDER_CNT_EN
   localparam logic [15:0] EXP_CNT_1 = 16'd1;
   localparam logic [15:0] EXP_CNT_3 = 16'd3;
   localparam logic [15:0] EXP_CNT_4 = 16'd4;
`else
   localparam logic [15:0] EXP_CNT_1 = 16'd0;
   localparam logic [15:0] EXP_CNT_3 = 16'd0;
   localparam logic [15:0] EXP_CNT_4 = 16'd0;
`endif

   sa4_skew_feeder_if #(.WIDTH(8)) ifc ();

   sa4_skew_feeder #(.WIDTH(8), .N(4)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .s_if       (ifc),
      .activation (activation),
      .weight     (weight),
      .control    (control),
      .busy       (busy),
      .done       (done),
      .beat_cnt   (beat_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ifc.in_valid  = 1'b0;
      ifc.in_last   = 1'b0;
      ifc.in_act    = 32'h0;
      ifc.in_weight = 32'h0;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      idle_inputs();
      #12;
      tests_run++;
      if (activation !== 32'h0 || weight !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_data: act=%h wt=%h expected 0", activation, weight);
      end
      tests_run++;
      if (control !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || beat_cnt !== 16'd0) begin
         tests_failed++;
         $display("FAIL reset_ctrl: control=%b busy=%b done=%b cnt=%h expected 0", control, busy, done, beat_cnt);
      end
      tests_run++;
      if (ifc.in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_ready: got %b expected 1", ifc.in_ready);
      end
      @(negedge clk);
      rstn = 1'b1;
      tick();
   endtask

   task automatic test_single_beat();
      logic [31:0] ea, ew;
      ifc.in_valid  = 1'b1;
      ifc.in_act    = 32'h01020304;
      ifc.in_weight = 32'h05060708;
      ifc.in_last   = 1'b1;
      tests_run++;
      if (ifc.in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL single_ready_idle: got %b expected 1", ifc.in_ready);
      end
      tick();
      idle_inputs();
      for (int k = 1; k <= 10; k++) begin
         case (k)
            1:       begin ea = 32'h01000000; ew = 32'h05000000; end
            2:       begin ea = 32'h00020000; ew = 32'h00060000; end
            3:       begin ea = 32'h00000300; ew = 32'h00000700; end
            4:       begin ea = 32'h00000004; ew = 32'h00000008; end
            default: begin ea = 32'h0;        ew = 32'h0;        end
         endcase
         tests_run++;
         if (activation !== ea || weight !== ew) begin
            tests_failed++;
            $display("FAIL single_data k=%0d: act=%h wt=%h expected %h %h", k, activation, weight, ea, ew);
         end
         tests_run++;
         if (control !== (k <= 8) || busy !== (k <= 8)) begin
            tests_failed++;
            $display("FAIL single_ctrl k=%0d: control=%b busy=%b expected %b", k, control, busy, (k <= 8));
         end
         tests_run++;
         if (done !== (k == 9) || ifc.in_ready !== (k >= 9)) begin
            tests_failed++;
            $display("FAIL single_done k=%0d: done=%b ready=%b expected %b %b", k, done, ifc.in_ready, (k == 9), (k >= 9));
         end
         tick();
      end
      tests_run++;
      if (beat_cnt !== EXP_CNT_1) begin
         tests_failed++;
         $display("FAIL single_cnt: got %h expected %h", beat_cnt, EXP_CNT_1);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] acts [4] = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 32'hD0D1D2D3};
      logic [31:0] wts  [4] = '{32'h50515253, 32'h60616263, 32'h70717273, 32'h80818283};
      logic [31:0] ea, ew;
      for (int j = 0; j < 4; j++) begin
         ifc.in_valid  = 1'b1;
         ifc.in_act    = acts[j];
         ifc.in_weight = wts[j];
         ifc.in_last   = (j == 3);
         tests_run++;
         if (ifc.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_ready beat=%0d: got %b expected 1", j, ifc.in_ready);
         end
         tick();
         if (j == 0) begin
            tests_run++;
            if (activation !== 32'hA0000000 || control !== 1'b1) begin
               tests_failed++;
               $display("FAIL b2b_first: act=%h control=%b expected a0000000 1", activation, control);
            end
         end
      end
      idle_inputs();
      for (int k = 1; k <= 10; k++) begin
         case (k)
            1:       begin ea = 32'hD0C1B2A3; ew = 32'h80716253; end
            2:       begin ea = 32'h00D1C2B3; ew = 32'h00817263; end
            3:       begin ea = 32'h0000D2C3; ew = 32'h00008273; end
            4:       begin ea = 32'h000000D3; ew = 32'h00000083; end
            default: begin ea = 32'h0;        ew = 32'h0;        end
         endcase
         tests_run++;
         if (activation !== ea || weight !== ew) begin
            tests_failed++;
            $display("FAIL b2b_data k=%0d: act=%h wt=%h expected %h %h", k, activation, weight, ea, ew);
         end
         tests_run++;
         if (ifc.in_ready !== (k >= 9) || control !== (k <= 8) || done !== (k == 9)) begin
            tests_failed++;
            $display("FAIL b2b_ctrl k=%0d: ready=%b control=%b done=%b", k, ifc.in_ready, control, done);
         end
         tick();
      end
      tests_run++;
      if (beat_cnt !== EXP_CNT_4) begin
         tests_failed++;
         $display("FAIL b2b_cnt: got %h expected %h", beat_cnt, EXP_CNT_4);
      end
   endtask

   task automatic test_bubble();
      logic [31:0] ea;
      bit          seen;
      ifc.in_valid = 1'b1; ifc.in_act = 32'hA0A1A2A3; ifc.in_last = 1'b0;
      tick();
      idle_inputs();
      tick();
      tests_run++;
      if (activation !== 32'h00A10000 || control !== 1'b1 || busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL bubble_gap: act=%h control=%b busy=%b expected 00a10000 1 1", activation, control, busy);
      end
      ifc.in_valid = 1'b1; ifc.in_act = 32'hB0B1B2B3; ifc.in_last = 1'b0;
      tick();
      ifc.in_valid = 1'b1; ifc.in_act = 32'hC0C1C2C3; ifc.in_last = 1'b1;
      tick();
      idle_inputs();
      for (int k = 1; k <= 5; k++) begin
         case (k)
            1:       ea = 32'hC0B100A3;
            2:       ea = 32'h00C1B200;
            3:       ea = 32'h0000C2B3;
            4:       ea = 32'h000000C3;
            default: ea = 32'h0;
         endcase
         tests_run++;
         if (activation !== ea || control !== 1'b1) begin
            tests_failed++;
            $display("FAIL bubble_data k=%0d: act=%h control=%b expected %h 1", k, activation, control, ea);
         end
         tick();
      end
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
         if (done === 1'b1) seen = 1'b1;
         else tick();
      end
      tests_run++;
      if (!seen) begin
         tests_failed++;
         $display("FAIL bubble_done_timeout: done not seen within 20 cycles");
      end
      tests_run++;
      if (beat_cnt !== EXP_CNT_3) begin
         tests_failed++;
         $display("FAIL bubble_cnt: got %h expected %h", beat_cnt, EXP_CNT_3);
      end
      tick();
   endtask

   task automatic test_hold_valid();
      logic [31:0] ea;
      bit          seen;
      ifc.in_valid = 1'b1; ifc.in_act = 32'h11121314; ifc.in_weight = 32'h0; ifc.in_last = 1'b1;
      tick();
      ifc.in_act = 32'hE0E1E2E3;
      for (int k = 1; k <= 9; k++) begin
         case (k)
            1:       ea = 32'h11000000;
            2:       ea = 32'h00120000;
            3:       ea = 32'h00001300;
            4:       ea = 32'h00000014;
            default: ea = 32'h0;
         endcase
         tests_run++;
         if (activation !== ea || ifc.in_ready !== (k == 9) || done !== (k == 9)) begin
            tests_failed++;
            $display("FAIL hold_flush k=%0d: act=%h ready=%b done=%b expected %h %b", k, activation, ifc.in_ready, done, ea, (k == 9));
         end
         tick();
      end
      idle_inputs();
      tests_run++;
      if (activation !== 32'hE0000000 || busy !== 1'b1 || beat_cnt !== EXP_CNT_1) begin
         tests_failed++;
         $display("FAIL hold_next_tile: act=%h busy=%b cnt=%h expected e0000000 1 %h", activation, busy, beat_cnt, EXP_CNT_1);
      end
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
         if (done === 1'b1) seen = 1'b1;
         else tick();
      end
      tests_run++;
      if (!seen) begin
         tests_failed++;
         $display("FAIL hold_done_timeout: done not seen within 20 cycles");
      end
      tick();
   endtask

   task automatic test_reset_mid_tile();
      int bad;
      ifc.in_valid = 1'b1; ifc.in_act = 32'hA0A1A2A3; ifc.in_weight = 32'h50515253; ifc.in_last = 1'b0;
      tick();
      ifc.in_act = 32'hB0B1B2B3; ifc.in_weight = 32'h60616263;
      #2;
      rstn = 1'b0;
      #1;
      tests_run++;
      if (activation !== 32'h0 || weight !== 32'h0 || control !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || beat_cnt !== 16'd0) begin
         tests_failed++;
         $display("FAIL midrst_async: act=%h wt=%h control=%b busy=%b done=%b cnt=%h expected all 0", activation, weight, control, busy, done, beat_cnt);
      end
      idle_inputs();
      @(negedge clk);
      rstn = 1'b1;
      tick();
      tests_run++;
      if (ifc.in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL midrst_ready: got %b expected 1", ifc.in_ready);
      end
      bad = 0;
      for (int t = 0; t < 12; t++) begin
         if (done !== 1'b0 || activation !== 32'h0 || busy !== 1'b0) bad++;
         tick();
      end
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL midrst_no_done: %0d bad cycles expected 0", bad);
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_single_beat();
      test_back_to_back();
      test_bubble();
      test_hold_valid();
      test_reset_mid_tile();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_sa4_skew_feeder

// File: doc/sa4_skew_feeder.md
SA4_SKEW_FEEDER -- requirements
Module: sa4_skew_feeder

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand lane width in bits.
REQ-002 Parameter N, default 4, SHALL set the array edge (lane count); only N=4 is supported.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 rstn  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 in_valid  input  1  SHALL mark in_act/in_weight/in_last as valid this cycle.
REQ-006 in_ready  output  1  SHALL indicate the feeder accepts a beat this cycle.
REQ-007 in_act  input  4*WIDTH  SHALL carry one activation column; bits [4*WIDTH-1 -: WIDTH] are lane 0.
REQ-008 in_weight  input  4*WIDTH  SHALL carry one weight row, with the same lane packing as in_act.
REQ-009 in_last  input  1  SHALL mark the final beat of a tile.
REQ-010 activation  output  4*WIDTH  SHALL drive the array's activation edge, skewed.
REQ-011 weight  output  4*WIDTH  SHALL drive the array's weight edge, skewed.
REQ-012 control  output  1  SHALL be the array accumulate-enable.
REQ-013 busy  output  1  SHALL be high whenever state is not IDLE.
REQ-014 done  output  1  SHALL pulse for one cycle when a tile is complete.
REQ-015 beat_cnt  output  16  SHALL report accepted beats of the current or last tile.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, STREAM, FLUSH and DONE.
REQ-017 Handshake: a beat is accepted when in_valid&&in_ready; in_ready SHALL be 1 in IDLE and STREAM, 0 in FLUSH and DONE.
REQ-018 IDLE->STREAM SHALL occur on an accepted beat with in_last=0; an accepted beat with in_last=1 in IDLE or STREAM SHALL go to FLUSH (K=1 is legal).
REQ-019 Skew: lane i of activation/weight SHALL equal lane i of the accepted beat delayed i+1 cycles (lane 0: 1 register, lane 3: 4 registers).
REQ-020 A cycle in STREAM with no accepted beat (bubble) SHALL inject an all-zero beat into the skew chain.
REQ-021 Zero beats SHALL be injected in IDLE, FLUSH and DONE, so the outputs are 0 once the chain drains.
REQ-022 FLUSH SHALL last FLUSH_LEN = 2*(N-1)+1 = 7 cycles, counted by a 3-bit down-counter, then go to DONE.
REQ-023 DONE SHALL last one cycle, assert done, and return to IDLE.
REQ-024 control SHALL be 1 in STREAM and FLUSH, and 1 in the cycle following the accepting IDLE cycle; it SHALL be 0 otherwise.
REQ-025 Net effect of REQ-024: control rises together with the first non-zero lane-0 output.
REQ-026 Operands SHALL pass unmodified; no arithmetic is performed on data.
REQ-027 beat_cnt SHALL clear on the first accepted beat of a tile and increment per accepted beat.
REQ-028 beat_cnt SHALL saturate at 16'hFFFF and hold its value through FLUSH, DONE and IDLE.
REQ-029 in_valid during FLUSH or DONE SHALL be ignored and SHALL NOT be lost, because in_ready=0.

Reset
REQ-030 While rstn=0, state SHALL be IDLE and all skew registers, counters, activation, weight, control, done, busy and beat_cnt SHALL be 0.
REQ-031 in_ready SHALL read 1 in reset, since reset state is IDLE.
REQ-032 Reset asserted mid-tile SHALL discard the tile without emitting done; no partial flush occurs.

Configuration
REQ-033 Macro SA4_FEEDER_CNT_EN defined: beat_cnt SHALL be implemented per REQ-027 and REQ-028.
REQ-034 Macro SA4_FEEDER_CNT_EN undefined: no counter logic SHALL exist and beat_cnt SHALL be tied to 0; all other behaviour is identical.

Structure
REQ-035 A shared package sa_pkg SHALL hold the state encoding (IDLE=2'd0, STREAM=2'd1, FLUSH=2'd2, DONE=2'd3), N, FLUSH_LEN and the lane slice width.
REQ-036 One sub-module, sa_skew_lane (a parameterised DEPTH-deep WIDTH-bit shift register with async reset), SHALL be instantiated 2*N times.

Verification
REQ-037 Reset then a single beat act=32'h01020304, wt=32'h05060708, last=1:
- activation lanes = 01, 02, 03, 04 at cycles +1, +2, +3, +4 after acceptance;
- control high for 8 cycles;
- done at cycle +9.
REQ-038 Four back-to-back beats, last on beat 4: in_ready=1 for 4 cycles then 0 for 8; beat_cnt=4; outputs zero after the final lane-3 value.
REQ-039 Three beats with a bubble between beats 1 and 2: the bubble appears as 0 on every lane in diagonal order; control stays 1; beat_cnt=3.
REQ-040 in_valid held high through FLUSH: no acceptance until IDLE; the next tile starts on the cycle after done.
REQ-041 rstn pulsed low at STREAM beat 2: all outputs 0 asynchronously, no done, in_ready=1 after release.
REQ-042 Build without SA4_FEEDER_CNT_EN and rerun REQ-038: beat_cnt=0, all other waveforms identical.
